// File: rtl/ceespu_imm_fuse_pkg.sv
// Shared constants for the IMM-prefix fusion stage: instruction field
// positions, the default prefix opcode and the two FSM states.
package ceespu_imm_fuse_pkg;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned IMM16_MSB = 15;
  localparam int unsigned IMM16_LSB = 0;

  localparam logic [5:0] IMM_OPCODE_DEFAULT = 6'b011110;

  typedef logic [31:0] insn_t;
  typedef logic [0:0]  fuse_state_t;

  localparam fuse_state_t ST_IDLE  = 1'b0;
  localparam fuse_state_t ST_ACCUM = 1'b1;

  function automatic logic is_imm_prefix(insn_t insn, logic [5:0] opc);
    return insn[OPC_MSB:OPC_LSB] == opc;
  endfunction

endpackage

// File: rtl/ceespu_imm_fuse_if.sv
// Fetch-side and decode-side handshake plus fused payload of the IMM fuse stage.
// Signal names are from the fuse stage's point of view (I_ = into it).
interface ceespu_imm_fuse_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 14
);
  localparam int unsigned NPFX = (XLEN - 16) / 16;
  localparam int unsigned CW   = $clog2(NPFX + 1);

  logic                I_valid;
  logic                O_ready;
  logic [31:0]         I_instruction;
  logic [PC_W-1:0]     I_PC;
  logic                I_ready;
  logic                O_valid;
  logic [31:0]         O_instruction;
  logic [PC_W-1:0]     O_PC;
  logic [XLEN-17:0]    O_imm_hi;
  logic                O_imm_hi_valid;
  logic [CW-1:0]       O_pfx_count;
  logic                O_irq_block;
  logic                O_pfx_overflow;

  modport slave (
    input  I_valid, I_instruction, I_PC, I_ready,
    output O_ready, O_valid, O_instruction, O_PC, O_imm_hi, O_imm_hi_valid,
           O_pfx_count, O_irq_block, O_pfx_overflow
  );

  modport master (
    output I_valid, I_instruction, I_PC, I_ready,
    input  O_ready, O_valid, O_instruction, O_PC, O_imm_hi, O_imm_hi_valid,
           O_pfx_count, O_irq_block, O_pfx_overflow
  );

endinterface

// File: rtl/ceespu_skid_buffer.sv
// Two-entry valid/ready register slice: an output register backed by one
// skid entry, so upstream ready depends only on local state.
module ceespu_skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_flush,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [WIDTH-1:0] I_data,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [WIDTH-1:0] O_data
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             skid_valid_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             push;

  assign O_ready = !skid_valid_q;
  assign push    = I_valid && !skid_valid_q;
  assign O_valid = out_valid_q;
  assign O_data  = out_data_q;

  // Fill the output register first; the skid entry only catches a push
  // that arrives while the output register is stalled.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n || I_flush) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (skid_valid_q) begin
      if (I_ready) begin
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end
    end else if (!out_valid_q || I_ready) begin
      out_valid_q <= push;
      if (push) begin
        out_data_q <= I_data;
      end
    end else if (push) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= I_data;
    end
  end

endmodule

// File: rtl/ceespu_imm_fuse.sv
// Front-of-decode IMM prefix fusion: absorbs chained seti prefixes and hands
// the next real instruction to decode with the accumulated upper immediate.
module ceespu_imm_fuse
  import ceespu_imm_fuse_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PC_W       = 14,
  parameter logic [5:0]  IMM_OPCODE = IMM_OPCODE_DEFAULT
) (
  input logic              I_clk,
  input logic              I_rst_n,
  input logic              I_flush,
  ceespu_imm_fuse_if.slave bus
);

  localparam int unsigned NPFX = (XLEN - 16) / 16;
  localparam int unsigned HW   = XLEN - 16;
  localparam int unsigned CW   = $clog2(NPFX + 1);
  localparam int unsigned PW   = 32 + PC_W + HW + 1 + CW;
  localparam logic [CW-1:0] CNT_MAX = CW'(NPFX);

  fuse_state_t     state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [HW-1:0]   acc_q, acc_d;
  logic [PC_W-1:0] grp_pc_q, grp_pc_d;
  logic            ovf_q, ovf_d;

  logic            skid_ready;
  logic            accept, is_pfx, pfx_acc, ins_acc;
  logic [PC_W-1:0] pc_sel;
  logic [PW-1:0]   in_data, out_data;

  // Keep the low 16*n accumulated bits and sign-extend from bit 16*n-1.
  function automatic logic [HW-1:0] sext_acc(logic [HW-1:0] a, logic [CW-1:0] n);
    logic [HW-1:0] r;
    r = '0;
    for (int i = 1; i <= int'(NPFX); i++) begin
      if (n == CW'(i)) begin
        for (int b = 0; b < int'(HW); b++) begin
          r[b] = (b < 16 * i) ? a[b] : a[16 * i - 1];
        end
      end
    end
    return r;
  endfunction

  assign bus.O_ready = skid_ready;
  assign accept      = bus.I_valid && skid_ready;
  assign is_pfx      = is_imm_prefix(bus.I_instruction, IMM_OPCODE);
  assign pfx_acc     = accept && is_pfx;
  assign ins_acc     = accept && !is_pfx;
  assign pc_sel      = (count_q != '0) ? grp_pc_q : bus.I_PC;
  assign in_data     = {bus.I_instruction, pc_sel, sext_acc(acc_q, count_q),
                        count_q != '0, count_q};

  // Prefix accumulation and group tracking.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    grp_pc_d = grp_pc_q;
    ovf_d    = 1'b0;
    if (pfx_acc) begin
      acc_d   = HW'({acc_q, bus.I_instruction[IMM16_MSB:IMM16_LSB]});
      ovf_d   = (count_q == CNT_MAX);
      count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
      state_d = ST_ACCUM;
      if (state_q == ST_IDLE) begin
        grp_pc_d = bus.I_PC;
      end
    end else if (ins_acc) begin
      state_d = ST_IDLE;
      count_d = '0;
      acc_d   = '0;
    end
  end

  // Group state register; reset and flush both abandon an open group.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n || I_flush) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      grp_pc_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      grp_pc_q <= grp_pc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.O_irq_block    = (state_q == ST_ACCUM);
  assign bus.O_pfx_overflow = ovf_q;

  ceespu_skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_flush (I_flush),
    .I_valid (ins_acc),
    .O_ready (skid_ready),
    .I_data  (in_data),
    .O_valid (bus.O_valid),
    .I_ready (bus.I_ready),
    .O_data  (out_data)
  );

  assign {bus.O_instruction, bus.O_PC, bus.O_imm_hi, bus.O_imm_hi_valid,
          bus.O_pfx_count} = out_data;

endmodule

// File: tb/tb_ceespu_imm_fuse.sv
// Bench for ceespu_imm_fuse: a 64-bit instance with a scoreboard and a
// 32-bit instance for the single-prefix case.
module tb_ceespu_imm_fuse;
  import ceespu_imm_fuse_pkg::*;

  localparam logic [5:0] IMM = IMM_OPCODE_DEFAULT;

  typedef struct packed {
    logic [31:0] ins;
    logic [13:0] pc;
    logic [47:0] imm;
    logic        v;
    logic [1:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush64;
  logic flush32;

  int checks = 0;
  int errors = 0;

  exp_t sbq[$];
  exp_t e;
  int   occ = 0;
  bit   mon_en = 0;
  bit   exp_irq = 0;
  bit   rnd_rdy = 0;
  int   ovf_seen = 0;

  logic [63:0] m_acc = '0;
  int          m_cnt = 0;
  logic [13:0] m_pc = '0;
  int          m_ovf = 0;

  ceespu_imm_fuse_if #(.XLEN(64), .PC_W(14)) bus64 ();
  ceespu_imm_fuse_if #(.XLEN(32), .PC_W(14)) bus32 ();

  ceespu_imm_fuse #(.XLEN(64), .PC_W(14), .IMM_OPCODE(IMM)) dut64 (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .I_flush (flush64),
    .bus     (bus64)
  );

  ceespu_imm_fuse #(.XLEN(32), .PC_W(14), .IMM_OPCODE(IMM)) dut32 (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .I_flush (flush32),
    .bus     (bus32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard, occupancy and group-open tracking for the 64-bit instance.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("o_ready", 64'(bus64.O_ready), 64'(occ < 2));
      chk("o_valid", 64'(bus64.O_valid), 64'(occ > 0));
      chk("irq_block", 64'(bus64.O_irq_block), 64'(exp_irq));
      if (bus64.O_pfx_overflow) ovf_seen++;
      if (bus64.O_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sbq[0];
          chk("out_ins", 64'(bus64.O_instruction), 64'(e.ins));
          chk("out_pc", 64'(bus64.O_PC), 64'(e.pc));
          chk("out_imm_hi", 64'(bus64.O_imm_hi), 64'(e.imm));
          chk("out_imm_v", 64'(bus64.O_imm_hi_valid), 64'(e.v));
          chk("out_cnt", 64'(bus64.O_pfx_count), 64'(e.cnt));
          if (bus64.I_ready) void'(sbq.pop_front());
        end
      end
      if (!rst_n || flush64) begin
        occ = 0;
      end else begin
        if (bus64.I_valid && bus64.O_ready && bus64.I_instruction[31:26] != IMM) occ++;
        if (bus64.O_valid && bus64.I_ready) occ--;
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      bus64.I_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic present(input logic [31:0] ins, input logic [13:0] pc);
    bit ok;
    ok = 0;
    bus64.I_valid = 1'b1;
    bus64.I_instruction = ins;
    bus64.I_PC = pc;
    for (int g = 0; g < 100 && !ok; g++) begin
      @(negedge clk);
      ok = bus64.O_ready;
      @(posedge clk);
      #1;
    end
    bus64.I_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_pfx(input logic [15:0] imm, input logic [13:0] pc);
    present({IMM, 10'h000, imm}, pc);
    if (m_cnt == 0) m_pc = pc;
    m_acc = {m_acc[47:0], imm};
    if (m_cnt == 3) m_ovf++;
    else m_cnt++;
    exp_irq = 1;
  endtask

  task automatic send_ins(input logic [31:0] ins, input logic [13:0] pc,
                          input logic [47:0] eimm, input logic ev,
                          input logic [1:0] ecnt, input logic [13:0] epc);
    present(ins, pc);
    sbq.push_back('{ins: ins, pc: epc, imm: eimm, v: ev, cnt: ecnt});
    m_cnt = 0;
    exp_irq = 0;
  endtask

  function automatic logic [47:0] model_imm();
    logic signed [63:0] t;
    int sh;
    if (m_cnt == 0) return '0;
    sh = 64 - 16 * m_cnt;
    t = $signed(m_acc << sh);
    t = t >>> sh;
    return t[47:0];
  endfunction

  task automatic drain();
    for (int g = 0; g < 300 && sbq.size() != 0; g++) @(posedge clk);
    #1;
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  logic [3:0]  pat;
  logic [31:0] rins;
  logic [5:0]  rop;
  logic [13:0] rpc;
  int          k;

  initial begin
    rst_n = 1'b0;
    flush64 = 1'b0;
    flush32 = 1'b0;
    bus64.I_valid = 1'b0;
    bus64.I_instruction = '0;
    bus64.I_PC = '0;
    bus64.I_ready = 1'b1;
    bus32.I_valid = 1'b0;
    bus32.I_instruction = '0;
    bus32.I_PC = '0;
    bus32.I_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(bus64.O_valid), 64'd0);
    chk("rst_ready", 64'(bus64.O_ready), 64'd1);
    chk("rst_imm", 64'(bus64.O_imm_hi), 64'd0);
    chk("rst_cnt", 64'(bus64.O_pfx_count), 64'd0);
    chk("rst_irq", 64'(bus64.O_irq_block), 64'd0);
    chk("rst_ovf", 64'(bus64.O_pfx_overflow), 64'd0);
    chk("rst32_ready", 64'(bus32.O_ready), 64'd1);
    @(posedge clk);
    #1;

    // XLEN=32: prefix DEAD at 0x010, ADDI at 0x011.
    bus32.I_valid = 1'b1;
    bus32.I_instruction = {IMM, 10'h000, 16'hDEAD};
    bus32.I_PC = 14'h010;
    @(negedge clk);
    chk("x32_pfx_ready", 64'(bus32.O_ready), 64'd1);
    @(posedge clk);
    #1;
    bus32.I_instruction = 32'h0411_0042;
    bus32.I_PC = 14'h011;
    @(negedge clk);
    chk("x32_irq_open", 64'(bus32.O_irq_block), 64'd1);
    chk("x32_no_out", 64'(bus32.O_valid), 64'd0);
    @(posedge clk);
    #1;
    bus32.I_valid = 1'b0;
    @(negedge clk);
    chk("x32_valid", 64'(bus32.O_valid), 64'd1);
    chk("x32_ins", 64'(bus32.O_instruction), 64'h0411_0042);
    chk("x32_imm", 64'(bus32.O_imm_hi), 64'hDEAD);
    chk("x32_imm_v", 64'(bus32.O_imm_hi_valid), 64'd1);
    chk("x32_cnt", 64'(bus32.O_pfx_count), 64'd1);
    chk("x32_pc", 64'(bus32.O_PC), 64'h010);
    chk("x32_irq_closed", 64'(bus32.O_irq_block), 64'd0);
    @(posedge clk);
    #1;

    mon_en = 1;

    // Three prefixes then LOAD.
    send_pfx(16'h8000, 14'h100);
    send_pfx(16'h1234, 14'h101);
    send_pfx(16'h5678, 14'h102);
    send_ins(32'h8C00_0004, 14'h103, 48'h8000_1234_5678, 1'b1, 2'd3, 14'h100);
    drain();

    // Four prefixes: oldest shifts out, one overflow pulse.
    ovf_seen = 0;
    send_pfx(16'h8000, 14'h110);
    send_pfx(16'h1234, 14'h111);
    send_pfx(16'h5678, 14'h112);
    send_pfx(16'h9ABC, 14'h113);
    send_ins(32'h8C00_0008, 14'h114, 48'h1234_5678_9ABC, 1'b1, 2'd3, 14'h110);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_once", 64'(ovf_seen), 64'd1);

    // Negative single prefix.
    send_pfx(16'hFFFE, 14'h120);
    send_ins(32'h0800_1111, 14'h121, 48'hFFFF_FFFF_FFFE, 1'b1, 2'd1, 14'h120);
    drain();

    // Back-to-back unprefixed stream with I_ready pattern 1,0,0,1.
    pat = 4'b1001;
    fork
      begin
        send_ins(32'h0000_00A1, 14'h200, 48'h0, 1'b0, 2'd0, 14'h200);
        send_ins(32'h0000_00B2, 14'h201, 48'h0, 1'b0, 2'd0, 14'h201);
        send_ins(32'h0000_00C3, 14'h202, 48'h0, 1'b0, 2'd0, 14'h202);
        send_ins(32'h0000_00D4, 14'h203, 48'h0, 1'b0, 2'd0, 14'h203);
      end
      begin
        @(posedge clk);
        #1;
        for (int i = 3; i >= 0; i--) begin
          bus64.I_ready = pat[i];
          @(posedge clk);
          #1;
        end
        bus64.I_ready = 1'b1;
      end
    join
    drain();

    // Prefix, flush (with a discarded instruction), then ADD.
    send_pfx(16'h4444, 14'h020);
    flush64 = 1'b1;
    bus64.I_valid = 1'b1;
    bus64.I_instruction = 32'h0000_0BAD;
    bus64.I_PC = 14'h025;
    @(posedge clk);
    #1;
    flush64 = 1'b0;
    bus64.I_valid = 1'b0;
    m_cnt = 0;
    exp_irq = 0;
    @(negedge clk);
    chk("flush_irq", 64'(bus64.O_irq_block), 64'd0);
    chk("flush_ready", 64'(bus64.O_ready), 64'd1);
    chk("flush_valid", 64'(bus64.O_valid), 64'd0);
    @(posedge clk);
    #1;
    send_ins(32'h0000_0ADD, 14'h030, 48'h0, 1'b0, 2'd0, 14'h030);
    drain();

    // Reset mid-group while an output is held.
    bus64.I_ready = 1'b0;
    send_ins(32'h0000_0777, 14'h300, 48'h0, 1'b0, 2'd0, 14'h300);
    send_pfx(16'h1111, 14'h301);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.delete();
    m_cnt = 0;
    exp_irq = 0;
    @(negedge clk);
    chk("rstm_valid", 64'(bus64.O_valid), 64'd0);
    chk("rstm_ready", 64'(bus64.O_ready), 64'd1);
    chk("rstm_irq", 64'(bus64.O_irq_block), 64'd0);
    chk("rstm_cnt", 64'(bus64.O_pfx_count), 64'd0);
    @(posedge clk);
    #1;
    bus64.I_ready = 1'b1;

    // Random groups against the model with random downstream stalls.
    ovf_seen = 0;
    m_ovf = 0;
    rpc = 14'h400;
    rnd_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 4);
      for (int p = 0; p < k; p++) begin
        send_pfx(16'($urandom), rpc);
        rpc++;
      end
      rop = 6'($urandom_range(0, 63));
      if (rop == IMM) rop = 6'd0;
      rins = {rop, 26'($urandom)};
      send_ins(rins, rpc, model_imm(), m_cnt > 0, 2'(m_cnt), (m_cnt > 0) ? m_pc : rpc);
      rpc++;
    end
    rnd_rdy = 0;
    @(posedge clk);
    #2;
    bus64.I_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("rand_ovf", 64'(ovf_seen), 64'(m_ovf));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
